// File: rtl/fetch_stage_if.sv
// Fetch-stage boundary: control from ID/hazard unit, imem req/ack port, IF/ID register outputs.
// The master modport is the fetch stage itself; the slave modport is its environment.
interface fetch_stage_if;
    logic        i_stall;
    logic        i_pcsrc;
    logic [31:0] i_nextpc;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_rdata;
    logic        o_id_valid;
    logic [31:0] o_id_instr;
    logic [31:0] o_id_pc4;
    logic [31:0] o_pc;

    modport master (
        input  i_stall, i_pcsrc, i_nextpc, i_imem_ack, i_imem_rdata,
        output o_imem_req, o_imem_addr, o_id_valid, o_id_instr, o_id_pc4, o_pc
    );

    modport slave (
        output i_stall, i_pcsrc, i_nextpc, i_imem_ack, i_imem_rdata,
        input  o_imem_req, o_imem_addr, o_id_valid, o_id_instr, o_id_pc4, o_pc
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, imem req/ack fetch, IF/ID pipeline register.
// Zero-wait memory gives one instruction per cycle; a stall that arrives while a fetch is in flight parks the returned word in a skid.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    fetch_stage_if.master bus
);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;
    logic        req;
    logic [31:0] redirect_pc;

    assign redirect_pc = bus.i_nextpc & 32'hFFFF_FFFC;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        id_valid_d   = id_valid_q;
        id_instr_d   = id_instr_q;
        id_pc4_d     = id_pc4_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        req          = 1'b0;

        case (state_q)
            S_FETCH: begin
                req = ~bus.i_stall & ~bus.i_pcsrc;
                if (bus.i_pcsrc) begin
                    pc_d       = redirect_pc;
                    id_valid_d = 1'b0;
                end else if (!bus.i_stall) begin
                    req_addr_d = pc_q;
                    if (bus.i_imem_ack) begin
                        id_valid_d = 1'b1;
                        id_instr_d = bus.i_imem_rdata;
                        id_pc4_d   = pc_q + 32'd4;
                        pc_d       = pc_q + 32'd4;
                    end else begin
                        id_valid_d = 1'b0;
                        state_d    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                req = 1'b1;
                if (bus.i_imem_ack) begin
                    if (bus.i_pcsrc) begin
                        pc_d       = redirect_pc;
                        id_valid_d = 1'b0;
                        state_d    = S_FETCH;
                    end else if (bus.i_stall) begin
                        // IF/ID is frozen, so the returned word waits in the skid.
                        skid_instr_d = bus.i_imem_rdata;
                        skid_pc4_d   = req_addr_q + 32'd4;
                        pc_d         = req_addr_q + 32'd4;
                        state_d      = S_HOLD;
                    end else begin
                        id_valid_d = 1'b1;
                        id_instr_d = bus.i_imem_rdata;
                        id_pc4_d   = req_addr_q + 32'd4;
                        pc_d       = req_addr_q + 32'd4;
                        state_d    = S_FETCH;
                    end
                end else if (bus.i_pcsrc) begin
                    pc_d       = redirect_pc;
                    id_valid_d = 1'b0;
                    state_d    = S_DROP;
                end else if (!bus.i_stall) begin
                    id_valid_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (bus.i_pcsrc) begin
                    skid_instr_d = 32'h0;
                    skid_pc4_d   = 32'h0;
                    pc_d         = redirect_pc;
                    id_valid_d   = 1'b0;
                    state_d      = S_FETCH;
                end else if (!bus.i_stall) begin
                    id_valid_d = 1'b1;
                    id_instr_d = skid_instr_q;
                    id_pc4_d   = skid_pc4_q;
                    state_d    = S_FETCH;
                end
            end
            S_DROP: begin
                // The abandoned request must still complete; its data is thrown away.
                req = 1'b1;
                if (bus.i_pcsrc) begin
                    pc_d       = redirect_pc;
                    id_valid_d = 1'b0;
                end else if (!bus.i_stall) begin
                    id_valid_d = 1'b0;
                end
                if (bus.i_imem_ack) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            id_valid_q   <= 1'b0;
            id_instr_q   <= 32'h0;
            id_pc4_q     <= 32'h0;
            skid_instr_q <= 32'h0;
            skid_pc4_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            id_valid_q   <= id_valid_d;
            id_instr_q   <= id_instr_d;
            id_pc4_q     <= id_pc4_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
        end
    end

    assign bus.o_imem_req  = req & i_rst_n;
    assign bus.o_imem_addr = (state_q == S_FETCH) ? pc_q : req_addr_q;
    assign bus.o_id_valid  = id_valid_q;
    assign bus.o_id_instr  = id_instr_q;
    assign bus.o_id_pc4    = id_pc4_q;
    assign bus.o_pc        = pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios, then random stall/redirect/ack-latency traffic,
// all checked against a transaction-level model of the fetch stream.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    // Model: PC, one outstanding request (possibly stale), one parked word, IF/ID contents.
    logic [31:0] m_pc, m_addr, m_sk_instr, m_sk_pc4, m_i, m_p4;
    logic        m_inflight, m_stale, m_skid, m_v;

    // Memory: acks after lat_cur extra cycles of req.
    int lat_cur, lat_cnt, mem_lat;
    bit lat_rand;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int next_lat();
        return lat_rand ? int'($urandom_range(0, 3)) : mem_lat;
    endfunction

    task automatic set_lat(input int n);
        lat_rand = 1'b0;
        mem_lat  = n;
        lat_cnt  = 0;
        lat_cur  = n;
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_addr = 32'h0; m_inflight = 1'b0; m_stale = 1'b0;
        m_skid = 1'b0; m_sk_instr = 32'h0; m_sk_pc4 = 32'h0;
        m_v = 1'b0; m_i = 32'h0; m_p4 = 32'h0;
        lat_cnt = 0;
        lat_cur = next_lat();
    endtask

    task automatic check_regs();
        chk("id_valid", bus.o_id_valid, m_v);
        chk("id_instr", bus.o_id_instr, m_i);
        chk("id_pc4", bus.o_id_pc4, m_p4);
        chk("pc", bus.o_pc, m_pc);
    endtask

    // One cycle; entered and left at posedge+1.
    task automatic step(input logic s, input logic p, input logic [31:0] np);
        logic        exp_req, ack;
        logic [31:0] exp_addr, npc, data;
        bus.i_stall  = s;
        bus.i_pcsrc  = p;
        bus.i_nextpc = np;
        #1;
        exp_req  = m_skid ? 1'b0 : (m_inflight ? 1'b1 : (~s & ~p));
        exp_addr = m_inflight ? m_addr : m_pc;
        chk("imem_req", bus.o_imem_req, exp_req);
        if (exp_req) chk("imem_addr", bus.o_imem_addr, exp_addr);
        if (bus.o_imem_req) begin
            if (lat_cnt >= lat_cur) begin
                bus.i_imem_ack = 1'b1;
                lat_cnt = 0;
                lat_cur = next_lat();
            end else begin
                lat_cnt++;
            end
        end
        bus.i_imem_rdata = mem_word(bus.o_imem_addr);
        ack  = bus.i_imem_ack;
        npc  = np & 32'hFFFF_FFFC;
        data = mem_word(exp_addr);

        if (m_skid) begin
            if (p) begin
                m_skid = 1'b0; m_pc = npc; m_v = 1'b0;
            end else if (!s) begin
                m_skid = 1'b0; m_v = 1'b1; m_i = m_sk_instr; m_p4 = m_sk_pc4;
            end
        end else if (exp_req && ack) begin
            m_inflight = 1'b0;
            if (m_stale) begin
                m_stale = 1'b0;
                if (p) begin m_pc = npc; m_v = 1'b0; end
                else if (!s) m_v = 1'b0;
            end else if (p) begin
                m_pc = npc; m_v = 1'b0;
            end else if (s) begin
                m_skid = 1'b1; m_sk_instr = data; m_sk_pc4 = exp_addr + 32'd4;
                m_pc = exp_addr + 32'd4;
            end else begin
                m_v = 1'b1; m_i = data; m_p4 = exp_addr + 32'd4; m_pc = exp_addr + 32'd4;
            end
        end else if (exp_req) begin
            if (!m_inflight) begin m_inflight = 1'b1; m_addr = exp_addr; end
            if (p) begin m_pc = npc; m_v = 1'b0; m_stale = 1'b1; end
            else if (!s) m_v = 1'b0;
        end else if (p) begin
            m_pc = npc; m_v = 1'b0;
        end

        @(posedge clk);
        #1;
        bus.i_imem_ack = 1'b0;
        check_regs();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_valid"}, bus.o_id_valid, 1'b0);
        chk({tag, "_instr"}, bus.o_id_instr, 32'h0);
        chk({tag, "_pc4"}, bus.o_id_pc4, 32'h0);
        chk({tag, "_pc"}, bus.o_pc, RST_PC);
        chk({tag, "_req"}, bus.o_imem_req, 1'b0);
    endtask

    initial begin
        bus.i_stall = 1'b0; bus.i_pcsrc = 1'b0; bus.i_nextpc = 32'h0;
        bus.i_imem_ack = 1'b0; bus.i_imem_rdata = 32'h0;
        set_lat(0);
        model_reset();
        #12;
        check_reset_vals("rst");
        @(posedge clk); #1 rst_n = 1'b1;

        // Zero-wait streaming from reset.
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 1'b0, 32'h0);
            chk("t1_valid", bus.o_id_valid, 1'b1);
            chk("t1_pc4", bus.o_id_pc4, RST_PC + 32'(4 * k));
        end

        // Two-cycle memory latency: bubbles while waiting.
        set_lat(2);
        step(1'b0, 1'b0, 32'h0); chk("t2_bubble0", bus.o_id_valid, 1'b0);
        step(1'b0, 1'b0, 32'h0); chk("t2_bubble1", bus.o_id_valid, 1'b0);
        step(1'b0, 1'b0, 32'h0); chk("t2_pc4", bus.o_id_pc4, 32'h14);

        // Stall lands while waiting: word parked, then released.
        step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        chk("t3_hold_pc4", bus.o_id_pc4, 32'h14);
        chk("t3_hold_pc", bus.o_pc, 32'h18);
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("t3_skid_valid", bus.o_id_valid, 1'b1);
        chk("t3_skid_pc4", bus.o_id_pc4, 32'h18);
        chk("t3_skid_instr", bus.o_id_instr, mem_word(32'h14));

        // Redirect while waiting: late data dropped, unaligned target forced aligned.
        set_lat(3);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h0000_0103);
        chk("t4_pc", bus.o_pc, 32'h100);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("t4_dropped", bus.o_id_valid, 1'b0);
        set_lat(0);
        step(1'b0, 1'b0, 32'h0);
        chk("t4_next_pc4", bus.o_id_pc4, 32'h104);

        // Redirect and stall together in FETCH.
        step(1'b1, 1'b1, 32'h0000_0040);
        chk("t5_pc", bus.o_pc, 32'h40);
        chk("t5_valid", bus.o_id_valid, 1'b0);

        // PC wrap.
        step(1'b0, 1'b1, 32'hFFFF_FFFE);
        step(1'b0, 1'b0, 32'h0);
        chk("wrap_pc4", bus.o_id_pc4, 32'h0);
        chk("wrap_pc", bus.o_pc, 32'h0);

        // Asynchronous reset in the middle of a wait.
        set_lat(3);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("arst");
        set_lat(0);
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        step(1'b0, 1'b0, 32'h0);
        chk("arst_first_pc4", bus.o_id_pc4, RST_PC + 32'd4);

        // Random traffic.
        lat_rand = 1'b1;
        lat_cnt  = 0;
        lat_cur  = next_lat();
        for (int n = 0; n < 3000; n++) begin
            logic        s, p;
            logic [31:0] np;
            s  = ($urandom_range(0, 3) == 0);
            p  = ($urandom_range(0, 9) == 0);
            np = $urandom;
            if ($urandom_range(0, 15) == 0) np = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            step(s, p, np);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
